// File: rtl/ulpb_tx_arbiter_pkg.sv
// Shared ULPB definitions: bus widths and arbiter state encodings.
// Imported by the TX arbiter, its interface and the testbench.
package ulpb_def;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_SEND    = 3'd1,
        ARB_WDONE   = 3'd2,
        ARB_NEXT    = 3'd3,
        ARB_RESULT  = 3'd4,
        ARB_RELEASE = 3'd5
    } arb_state_t;

endpackage

// File: rtl/ulpb_tx_arbiter_if.sv
// Client-side and node-side signals of the ULPB TX arbiter.
// master = arbiter view, slave = clients/node view.
interface ulpb_tx_arbiter_if
    import ulpb_def::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
);
    logic [NUM_REQ*ADDR_WIDTH-1:0] C_ADDR;
    logic [NUM_REQ*DATA_WIDTH-1:0] C_DATA;
    logic [NUM_REQ-1:0]            C_PEND;
    logic [NUM_REQ-1:0]            C_PRIORITY;
    logic [NUM_REQ-1:0]            C_REQ;
    logic [NUM_REQ-1:0]            C_ACK;
    logic [NUM_REQ-1:0]            C_SUCC;
    logic [NUM_REQ-1:0]            C_FAIL;
    logic [NUM_REQ-1:0]            C_RESP_ACK;
    logic [ADDR_WIDTH-1:0]         TX_ADDR;
    logic [DATA_WIDTH-1:0]         TX_DATA;
    logic                          TX_PEND;
    logic                          PRIORITY;
    logic                          TX_REQ;
    logic                          TX_ACK;
    logic                          TX_SUCC;
    logic                          TX_FAIL;
    logic                          TX_RESP_ACK;
    logic                          BUSY;
    logic [GW-1:0]                 GRANT_ID;

    modport master (
        input  C_ADDR, C_DATA, C_PEND, C_PRIORITY, C_REQ, C_RESP_ACK,
        input  TX_ACK, TX_SUCC, TX_FAIL,
        output C_ACK, C_SUCC, C_FAIL,
        output TX_ADDR, TX_DATA, TX_PEND, PRIORITY, TX_REQ, TX_RESP_ACK,
        output BUSY, GRANT_ID
    );

    modport slave (
        output C_ADDR, C_DATA, C_PEND, C_PRIORITY, C_REQ, C_RESP_ACK,
        output TX_ACK, TX_SUCC, TX_FAIL,
        input  C_ACK, C_SUCC, C_FAIL,
        input  TX_ADDR, TX_DATA, TX_PEND, PRIORITY, TX_REQ, TX_RESP_ACK,
        input  BUSY, GRANT_ID
    );

endinterface

// File: rtl/ulpb_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: priority requesters first,
// otherwise any requester, scanning upward from rr with wrap.
module ulpb_rr_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  prio_i,
    input  logic [GW-1:0] rr_i,
    output logic          vld_o,
    output logic [GW-1:0] idx_o
);

    logic          pfound;
    logic          nfound;
    logic [GW-1:0] pidx;
    logic [GW-1:0] nidx;
    logic [GW-1:0] jj;
    int            j;

    // first priority requester and first plain requester from rr
    always_comb begin
        pfound = 1'b0;
        nfound = 1'b0;
        pidx   = '0;
        nidx   = '0;
        jj     = '0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = GW'(j);
            if (!pfound && req_i[jj] && prio_i[jj]) begin
                pfound = 1'b1;
                pidx   = jj;
            end
            if (!nfound && req_i[jj]) begin
                nfound = 1'b1;
                nidx   = jj;
            end
        end
        vld_o = |req_i;
        idx_o = pfound ? pidx : nidx;
    end

endmodule

// File: rtl/ulpb_tx_arbiter.sv
// Shares one ULPB node TX port between NUM_REQ clients; the grant
// is locked for a whole TX_PEND chain and the result is routed back.
module ulpb_tx_arbiter
    import ulpb_def::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic              CLK,
    input  logic              RESET,
    ulpb_tx_arbiter_if.master bus
);

    arb_state_t              state_q, state_d;
    logic [GW-1:0]           g_q, g_d;
    logic [GW-1:0]           rr_q, rr_d;
    logic [GW-1:0]           sel;
    logic [GW-1:0]           pick_idx;
    logic                    pick_vld;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    pend_q, pend_d;
    logic                    prio_q, prio_d;
    logic                    txreq_q, txreq_d;
    logic                    resp_q, resp_d;
    logic                    busy_q;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [NUM_REQ-1:0]      succ_q, succ_d;
    logic [NUM_REQ-1:0]      fail_q, fail_d;
    logic [ADDR_WIDTH-1:0]   c_addr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   c_data [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign c_addr[i] = bus.C_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign c_data[i] = bus.C_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end

    ulpb_rr_pick #(
        .N  (NUM_REQ),
        .GW (GW)
    ) u_pick (
        .req_i  (bus.C_REQ),
        .prio_i (bus.C_PRIORITY),
        .rr_i   (rr_q),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    // word source: the arbitration winner when idle, else the owner
    assign sel = (state_q == ARB_IDLE) ? pick_idx : g_q;

    // next-state and output-register logic of the grant FSM
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        pend_d  = pend_q;
        prio_d  = prio_q;
        txreq_d = txreq_q;
        resp_d  = resp_q;
        ack_d   = ack_q;
        succ_d  = succ_q;
        fail_d  = fail_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    g_d     = pick_idx;
                    addr_d  = c_addr[sel];
                    data_d  = c_data[sel];
                    pend_d  = bus.C_PEND[sel];
                    prio_d  = bus.C_PRIORITY[sel];
                    txreq_d = 1'b1;
                    state_d = ARB_SEND;
                end
            end
            ARB_SEND: begin
                if (bus.TX_FAIL) begin
                    txreq_d = 1'b0;
                    state_d = ARB_RESULT;
                end else if (bus.TX_ACK) begin
                    txreq_d    = 1'b0;
                    ack_d[g_q] = 1'b1;
                    state_d    = ARB_WDONE;
                end
            end
            ARB_WDONE: begin
                if (!bus.C_REQ[g_q] && !bus.TX_ACK) begin
                    ack_d   = '0;
                    state_d = pend_q ? ARB_NEXT : ARB_RESULT;
                end
            end
            ARB_NEXT: begin
                if (bus.TX_FAIL) begin
                    state_d = ARB_RESULT;
                end else if (bus.C_REQ[g_q]) begin
                    addr_d  = c_addr[sel];
                    data_d  = c_data[sel];
                    pend_d  = bus.C_PEND[sel];
                    prio_d  = bus.C_PRIORITY[sel];
                    txreq_d = 1'b1;
                    state_d = ARB_SEND;
                end
            end
            ARB_RESULT: begin
                if (!(succ_q[g_q] || fail_q[g_q])) begin
                    if (bus.TX_FAIL) begin
                        fail_d[g_q] = 1'b1;
                    end else if (bus.TX_SUCC) begin
                        succ_d[g_q] = 1'b1;
                    end
                end else if (bus.C_RESP_ACK[g_q]) begin
                    resp_d  = 1'b1;
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                if (!bus.TX_SUCC && !bus.TX_FAIL) begin
                    resp_d  = 1'b0;
                    succ_d  = '0;
                    fail_d  = '0;
                    rr_d    = (g_q == GW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // state and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ARB_IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
            prio_q  <= 1'b0;
            txreq_q <= 1'b0;
            resp_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            succ_q  <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            prio_q  <= prio_d;
            txreq_q <= txreq_d;
            resp_q  <= resp_d;
            busy_q  <= (state_d != ARB_IDLE);
            ack_q   <= ack_d;
            succ_q  <= succ_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.TX_ADDR     = addr_q;
    assign bus.TX_DATA     = data_q;
    assign bus.TX_PEND     = pend_q;
    assign bus.PRIORITY    = prio_q;
    assign bus.TX_REQ      = txreq_q;
    assign bus.TX_RESP_ACK = resp_q;
    assign bus.C_ACK       = ack_q;
    assign bus.C_SUCC      = succ_q;
    assign bus.C_FAIL      = fail_q;
    assign bus.BUSY        = busy_q;
    assign bus.GRANT_ID    = g_q;

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Randomized bench for ulpb_tx_arbiter: behavioural clients, a node
// model and a reference arbitration rule checked every cycle.
module tb_ulpb_tx_arbiter;
    import ulpb_def::*;

    localparam int N  = 4;
    localparam int GW = 2;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    ulpb_tx_arbiter_if #(.NUM_REQ(N), .GW(GW)) bus ();

    ulpb_tx_arbiter #(.NUM_REQ(N), .GW(GW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    // client models
    int          cph [N];
    int          nw  [N];
    int          wi  [N];
    int          dly [N];
    logic [7:0]  maddr [N];
    logic [31:0] mdata [N][3];
    logic        mprio [N];
    // node model
    int          nst;
    int          ndly;
    logic        npend;
    logic [1:0]  nexp;
    // arbitration model
    logic        mbusy;
    int          mown;
    int          mrr;
    bit          gen_en;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // winner = requester nearest at/after rr; priority set first if any
    function automatic int ref_pick(input logic [N-1:0] rq,
                                    input logic [N-1:0] pr, input int rr);
        int  best;
        int  bd;
        int  d;
        bit  usep;
        best = -1;
        bd   = N + 1;
        usep = |(rq & pr);
        for (int i = 0; i < N; i++) begin
            if (rq[i] && (!usep || pr[i])) begin
                d = (i - rr + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic drive_word(input int i);
        bus.C_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] = maddr[i];
        bus.C_DATA[i*DATA_WIDTH +: DATA_WIDTH] = mdata[i][wi[i]];
        bus.C_PEND[i]     = (wi[i] < nw[i] - 1);
        bus.C_PRIORITY[i] = mprio[i];
        bus.C_REQ[i]      = 1'b1;
    endtask

    task automatic new_msg(input int i, input bit allow_prio);
        nw[i] = $urandom_range(1, 3);
        wi[i] = 0;
        maddr[i] = 8'($urandom);
        for (int w = 0; w < 3; w++) mdata[i][w] = $urandom;
        mprio[i] = allow_prio && ($urandom_range(0, 3) == 0);
        cph[i] = 1;
        dly[i] = 0;
        drive_word(i);
    endtask

    task automatic take_result(input int i);
        chk("res_owner", i, mown);
        chk("res_kind", {bus.C_SUCC[i], bus.C_FAIL[i]}, nexp);
        bus.C_REQ[i]      = 1'b0;
        bus.C_RESP_ACK[i] = 1'b1;
        cph[i] = 4;
    endtask

    task automatic models_reset();
        for (int i = 0; i < N; i++) begin
            cph[i] = 0;
            nw[i]  = 0;
            wi[i]  = 0;
            dly[i] = 0;
        end
        bus.C_ADDR      = '0;
        bus.C_DATA      = '0;
        bus.C_PEND      = '0;
        bus.C_PRIORITY  = '0;
        bus.C_REQ       = '0;
        bus.C_RESP_ACK  = '0;
        bus.TX_ACK      = 1'b0;
        bus.TX_SUCC     = 1'b0;
        bus.TX_FAIL     = 1'b0;
        nst   = 0;
        ndly  = 0;
        npend = 1'b0;
        nexp  = 2'b00;
        mbusy = 1'b0;
        mown  = 0;
        mrr   = 0;
    endtask

    task automatic reset_chk(input string p);
        chk({p, "_c_ack"}, bus.C_ACK, 0);
        chk({p, "_c_succ"}, bus.C_SUCC, 0);
        chk({p, "_c_fail"}, bus.C_FAIL, 0);
        chk({p, "_tx_addr"}, bus.TX_ADDR, 0);
        chk({p, "_tx_data"}, bus.TX_DATA, 0);
        chk({p, "_tx_pend"}, bus.TX_PEND, 0);
        chk({p, "_prio"}, bus.PRIORITY, 0);
        chk({p, "_tx_req"}, bus.TX_REQ, 0);
        chk({p, "_resp_ack"}, bus.TX_RESP_ACK, 0);
        chk({p, "_busy"}, bus.BUSY, 0);
        chk({p, "_grant"}, bus.GRANT_ID, 0);
    endtask

    task automatic node_step();
        int r2;
        case (nst)
            0: if (bus.TX_REQ) begin
                if (ndly > 0) begin
                    ndly--;
                end else begin
                    chk("word_busy", mbusy, 1);
                    if (wi[mown] > 0 && $urandom_range(0, 5) == 0) begin
                        bus.TX_FAIL = 1'b1;
                        nexp = 2'b01;
                        nst  = 3;
                    end else begin
                        chk("word_gid", bus.GRANT_ID, mown);
                        chk("word_addr", bus.TX_ADDR, maddr[mown]);
                        chk("word_data", bus.TX_DATA, mdata[mown][wi[mown]]);
                        chk("word_pend", bus.TX_PEND, wi[mown] < nw[mown] - 1);
                        chk("word_prio", bus.PRIORITY, mprio[mown]);
                        npend = bus.TX_PEND;
                        bus.TX_ACK = 1'b1;
                        nst = 1;
                    end
                    ndly = $urandom_range(0, 3);
                end
            end
            1: if (!bus.TX_REQ) begin
                bus.TX_ACK = 1'b0;
                nst  = npend ? 0 : 2;
                ndly = $urandom_range(0, 3);
            end
            2: if (ndly > 0) begin
                ndly--;
            end else begin
                r2 = $urandom_range(0, 3);
                bus.TX_SUCC = (r2 != 1);
                bus.TX_FAIL = (r2 == 1) || (r2 == 2);
                nexp = bus.TX_FAIL ? 2'b01 : 2'b10;
                nst  = 3;
            end
            3: begin
                chk("res_txreq", bus.TX_REQ, 0);
                chk("res_cack", bus.C_ACK, 0);
                if (bus.TX_RESP_ACK) begin
                    bus.TX_SUCC = 1'b0;
                    bus.TX_FAIL = 1'b0;
                    nst = 4;
                end
            end
            4: if (!bus.TX_RESP_ACK) begin
                nst  = 0;
                ndly = $urandom_range(0, 3);
            end
            default: nst = 0;
        endcase
    endtask

    task automatic step();
        int          e;
        logic        r;
        logic [N-1:0] m;
        @(negedge CLK);
        chk("ack_1hot", $onehot0(bus.C_ACK), 1);
        chk("succ_1hot", $onehot0(bus.C_SUCC), 1);
        chk("fail_1hot", $onehot0(bus.C_FAIL), 1);
        chk("succ_fail", |(bus.C_SUCC & bus.C_FAIL), 0);
        if (!mbusy && bus.BUSY) begin
            e = ref_pick(bus.C_REQ, bus.C_PRIORITY, mrr);
            chk("grant", bus.GRANT_ID, e);
            chk("grant_txreq", bus.TX_REQ, 1);
            mbusy = 1'b1;
            mown  = (e < 0) ? 0 : e;
        end else if (mbusy && !bus.BUSY) begin
            chk("idle_gid", bus.GRANT_ID, mown);
            mbusy = 1'b0;
            mrr   = (mown + 1) % N;
        end
        m = '0;
        if (mbusy) m[mown] = 1'b1;
        chk("route", (bus.C_ACK | bus.C_SUCC | bus.C_FAIL) & ~m, 0);
        node_step();
        for (int i = 0; i < N; i++) begin
            r = bus.C_SUCC[i] | bus.C_FAIL[i];
            case (cph[i])
                0: if (gen_en && $urandom_range(0, 7) == 0) new_msg(i, 1'b1);
                1: if (r) take_result(i);
                   else if (bus.C_ACK[i]) begin
                       bus.C_REQ[i] = 1'b0;
                       wi[i]++;
                       cph[i] = 2;
                   end else if (dly[i] > 0) dly[i]--;
                   else drive_word(i);
                2: if (r) take_result(i);
                   else if (!bus.C_ACK[i]) begin
                       if (wi[i] < nw[i]) begin
                           cph[i] = 1;
                           dly[i] = $urandom_range(1, 3);
                       end else begin
                           cph[i] = 3;
                       end
                   end
                3: if (r) take_result(i);
                4: if (!r) begin
                       bus.C_RESP_ACK[i] = 1'b0;
                       cph[i] = 0;
                   end
                default: cph[i] = 0;
            endcase
        end
    endtask

    initial begin
        bit found;
        bit idle;
        gen_en = 1'b0;
        models_reset();
        repeat (2) @(negedge CLK);
        reset_chk("rst0");
        RESET = 1'b0;
        new_msg(0, 1'b0);
        step();
        gen_en = 1'b1;
        repeat (3000) step();

        found = 1'b0;
        for (int t = 0; t < 5000 && !found; t++) begin
            step();
            if (mbusy && cph[mown] == 1 && wi[mown] > 0 &&
                dly[mown] > 0 && nst == 0) found = 1'b1;
        end
        chk("mid_found", found, 1);
        RESET = 1'b1;
        @(negedge CLK);
        reset_chk("rst_mid");
        models_reset();
        RESET = 1'b0;
        for (int i = 0; i < N; i++) new_msg(i, 1'b0);
        step();
        repeat (2000) step();

        gen_en = 1'b0;
        idle = 1'b0;
        for (int t = 0; t < 5000 && !idle; t++) begin
            step();
            idle = !mbusy && nst == 0;
            for (int i = 0; i < N; i++) if (cph[i] != 0) idle = 1'b0;
        end
        chk("drain", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
